// File: rtl/rtc_preset_arbiter.sv
// Round-robin arbiter that validates a packed preset time word and loads it into the RTC counter.
// Optional LOAD watchdog: define PRESET_TIMEOUT_EN to abort a LOAD that sees no tick_i for TIMEOUT_CYC cycles.
module rtc_preset_arbiter #(
    parameter logic [27:0] TIMEOUT_CYC = 28'd200000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tick_i,
    input  logic        run_i,
    input  logic        host_valid_i,
    input  logic [43:0] host_time_i,
    output logic        host_ready_o,
    input  logic        sync_valid_i,
    input  logic [43:0] sync_time_i,
    output logic        sync_ready_o,
    output logic        resp_err_o,
    output logic        enable_o,
    output logic        en_preset_o,
    output logic [5:0]  init_sec_o,
    output logic [5:0]  init_min_o,
    output logic [5:0]  init_hour_o,
    output logic [1:0]  init_mode_o,
    output logic [2:0]  init_day_of_week_o,
    output logic [4:0]  init_day_of_month_o,
    output logic [3:0]  init_month_o,
    output logic [11:0] init_year_o,
    output logic        busy_o,
    output logic        timeout_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]  state;
    logic        grant_sync;
    logic        last_sync;
    logic        err_q;
    logic [43:0] word_q;

    logic [11:0] w_year;
    logic [3:0]  w_month;
    logic [4:0]  w_dom;
    logic [2:0]  w_dow;
    logic [1:0]  w_mode;
    logic [5:0]  w_hour;
    logic [5:0]  w_min;
    logic [5:0]  w_sec;

    assign {w_year, w_month, w_dom, w_dow, w_mode, w_hour, w_min, w_sec} = word_q;

    logic [4:0] dom_max;
    logic       hour_ok;
    logic       word_ok;
    logic       pick_sync;
    logic       load_expired;

    // NOTE: default assignment first so no path through the case can infer a latch.
    always_comb begin
        dom_max = 5'd31;
        case (w_month)
            4'd2:                   dom_max = (w_year[1:0] == 2'b00) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: dom_max = 5'd30;
            default:                dom_max = 5'd31;
        endcase
    end

    // 12-hour mode uses mode[1] as the PM flag, so only the hour range changes.
    assign hour_ok = w_mode[0] ? ((w_hour >= 6'd1) && (w_hour <= 6'd12))
                               : (w_hour <= 6'd23);

    assign word_ok = (w_sec <= 6'd59) && (w_min <= 6'd59) && hour_ok
                  && (w_dow != 3'd0)
                  && (w_month >= 4'd1) && (w_month <= 4'd12)
                  && (w_dom != 5'd0) && (w_dom <= dom_max);

    // Sync wins only when it is alone or host was served last.
    assign pick_sync = sync_valid_i && (!host_valid_i || !last_sync);

`ifdef PRESET_TIMEOUT_EN
    logic [27:0] load_cnt;
    logic        timeout_q;

    assign load_expired = (load_cnt == TIMEOUT_CYC - 28'd1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            load_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state != ST_LOAD)
                load_cnt <= '0;
            else if (!tick_i)
                load_cnt <= load_cnt + 28'd1;
            if ((state == ST_LOAD) && !tick_i && load_expired)
                timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;

    assign load_expired       = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout_o          = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state               <= ST_IDLE;
            grant_sync          <= 1'b0;
            last_sync           <= 1'b1;
            err_q               <= 1'b0;
            word_q              <= '0;
            init_sec_o          <= '0;
            init_min_o          <= '0;
            init_hour_o         <= '0;
            init_mode_o         <= '0;
            init_day_of_week_o  <= '0;
            init_day_of_month_o <= '0;
            init_month_o        <= '0;
            init_year_o         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (host_valid_i || sync_valid_i) begin
                        grant_sync <= pick_sync;
                        last_sync  <= pick_sync;
                        word_q     <= pick_sync ? sync_time_i : host_time_i;
                        state      <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (word_ok) begin
                        state               <= ST_LOAD;
                        err_q               <= 1'b0;
                        init_sec_o          <= w_sec;
                        init_min_o          <= w_min;
                        init_hour_o         <= w_hour;
                        init_mode_o         <= w_mode;
                        init_day_of_week_o  <= w_dow;
                        init_day_of_month_o <= w_dom;
                        init_month_o        <= w_month;
                        init_year_o         <= w_year;
                    end else begin
                        state <= ST_DONE;
                        err_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (tick_i) begin
                        state <= ST_DONE;
                        err_q <= 1'b0;
                    end else if (load_expired) begin
                        state <= ST_DONE;
                        err_q <= 1'b1;
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            enable_o <= 1'b0;
        else
            enable_o <= run_i;
    end

    assign busy_o       = (state != ST_IDLE);
    assign en_preset_o  = (state == ST_LOAD);
    assign host_ready_o = (state == ST_DONE) && !grant_sync;
    assign sync_ready_o = (state == ST_DONE) && grant_sync;
    assign resp_err_o   = (state == ST_DONE) && err_q;

endmodule

// File: doc/rtc_preset_arbiter.md
RTC_PRESET_ARBITER -- requirements
Module: rtc_preset_arbiter
Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 28'd200000000, meaning clk_i cycles allowed in LOAD before abort.
REQ-002 SHALL have ports: clk_i in 1 system clock; rst_i in 1 reset, synchronous, active-high.
REQ-003 SHALL have tick_i in 1: one-cycle strobe in the clk_i domain marking each counter 1 Hz edge.
REQ-004 SHALL have run_i in 1: user count enable.
REQ-005 SHALL have host_valid_i in 1, host_time_i in 44, host_ready_o out 1: requester 0 (register write).
REQ-006 SHALL have sync_valid_i in 1, sync_time_i in 44, sync_ready_o out 1: requester 1 (external time source).
REQ-007 SHALL have resp_err_o out 1: qualifies the ready pulse; 1 = request rejected or aborted.
REQ-008 SHALL have enable_o out 1, en_preset_o out 1, and init_sec_o 6, init_min_o 6, init_hour_o 6, init_mode_o 2, init_day_of_week_o 3, init_day_of_month_o 5, init_month_o 4, init_year_o 12 (all out): drive the time counter.
REQ-009 SHALL have busy_o out 1 (not IDLE) and timeout_o out 1 (sticky abort flag).
REQ-010 SHALL pack the time word as {year[43:32], month[31:28], dom[27:23], dow[22:20], mode[19:18], hour[17:12], min[11:6], sec[5:0]}.
Function
REQ-011 SHALL implement FSM IDLE -> CHECK -> LOAD -> DONE -> IDLE.
REQ-012 IDLE: on any valid_i, SHALL grant round-robin (priority to the requester not granted last; host after reset) and latch that word; the ungranted valid stays pending.
REQ-013 CHECK (1 cycle): SHALL validate sec<=59, min<=59, dow 1..7, month 1..12, dom 1..days(month,year).
REQ-014 Hour rule: mode[0]=0 -> hour 0..23; mode[0]=1 -> hour 1..12, with mode[1] as the PM flag.
REQ-015 days(): 31/30 per calendar; Feb = 29 when year[1:0]==0, else 28.
REQ-016 Illegal word SHALL go CHECK -> DONE with error, with no en_preset_o pulse.
REQ-017 LOAD: en_preset_o=1 and init_*_o = latched fields; stay until the cycle where tick_i=1, then -> DONE ok.
REQ-018 DONE (1 cycle): SHALL pulse the granted requester's ready_o with resp_err_o; en_preset_o=0.
REQ-019 Requesters SHALL hold valid_i and data until their ready_o; data changes while granted are ignored (latched copy used).
REQ-020 init_*_o SHALL hold their last value outside LOAD.
REQ-021 enable_o SHALL be run_i registered one cycle, unaffected by FSM state.
REQ-022 tick_i arriving in the CHECK cycle SHALL be ignored; LOAD waits for the next tick.
REQ-023 Both valids in the same IDLE cycle SHALL be served back-to-back per REQ-012, with exactly one IDLE cycle between transactions.
REQ-024 Throughput: at most one transaction in flight; latency = 1 (CHECK) + wait-for-tick + 1 (DONE).
Reset
REQ-025 rst_i SHALL force IDLE, last-grant=sync (host wins next), all outputs 0, and init_*_o 0.
REQ-026 rst_i mid-LOAD SHALL drop en_preset_o next cycle with no ready_o pulse for the aborted request.
Configuration
REQ-027 With PRESET_TIMEOUT_EN defined: a LOAD cycle counter SHALL abort after TIMEOUT_CYC cycles without tick_i -> DONE with error, en_preset_o dropped, timeout_o set; only rst_i clears timeout_o.
REQ-028 Without PRESET_TIMEOUT_EN: LOAD SHALL wait indefinitely, the counter is absent, and timeout_o is tied 0.
Verification
REQ-029 Host word 2021-12-31 dow7 23:59:58 mode0 and tick after 5 cycles -> en_preset_o high for 5 cycles with init_year_o=2021, then host_ready_o=1 and resp_err_o=0 one cycle after the tick.
REQ-030 host_valid_i and sync_valid_i both raised in the same cycle after reset -> host served first, sync second, no en_preset_o gap longer than wait-for-tick + 3 cycles.
REQ-031 Illegal words -> ready with resp_err_o=1 and no en_preset_o: dom=29 month=2 year=2021; hour=0 mode=01; sec=60.
REQ-032 Dom=29 month=2 year=2004 -> accepted, resp_err_o=0.
REQ-033 With PRESET_TIMEOUT_EN and TIMEOUT_CYC=16, no tick -> after 16 LOAD cycles ready with error and timeout_o=1 until rst_i.
REQ-034 rst_i during LOAD -> next cycle en_preset_o=0, busy_o=0, no ready_o pulse; a held valid is re-granted afterwards.
